fetch_buf_reader: RTL and testbench

Decode-side reader of the two-half instruction fetch buffer. Fetch fills the halves using the f_ld_buf load strobes. This block holds the 32-byte buffer and the byte read pointer. It presents a 16-byte rotated window to the decoder and frees each half once decode has consumed past it. It also drives de_p and r_V_de back to the fetch FSM.

---
 rtl/fetch_buf_reader.sv | 163 ++++++++++++++++
 tb/tb_fetch_buf_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buf_reader.sv
// fetch_buf_reader: decode-side reader of the two-half instruction fetch buffer.
// Holds the 2*LINE_BYTES byte buffer, the half-valid bits and the byte read
// pointer, and presents a rotated LINE_BYTES window to the decoder.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   f_ld_buf     per-half load strobe (2'b11 = restart load into current half)
//   f_line       line from icache, byte 0 in LSBs
//   flush        redirect: drop buffer contents, reload pointer from flush_off
//   de_take      decoder consumes de_len bytes (legal 1..LINE_BYTES)
//   win_bytes    window, byte k = buffer[(ptr+k) mod 2L]
//   r_V_de       full window valid
//   win_avail    contiguous valid bytes from ptr, capped at LINE_BYTES
//   de_p         half currently being decoded (ptr MSB)
//   len_err      one-cycle pulse: illegal take length ignored
//   ld_err       one-cycle pulse: load into occupied half ignored
module fetch_buf_reader #(
   parameter  int unsigned LINE_BYTES = 16,
   localparam int unsigned PW         = $clog2(2 * LINE_BYTES),
   localparam int unsigned LW         = 8 * LINE_BYTES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    f_ld_buf,
   input  logic [LW-1:0] f_line,
   input  logic          flush,
   input  logic [PW-1:0] flush_off,
   input  logic          de_take,
   input  logic [PW-1:0] de_len,
   output logic [LW-1:0] win_bytes,
   output logic          r_V_de,
   output logic [PW-1:0] win_avail,
   output logic          de_p,
   output logic          len_err,
   output logic          ld_err
);

   localparam int unsigned BUF_BYTES = 2 * LINE_BYTES;

   logic [LW-1:0] r_buf0;
   logic [LW-1:0] r_buf1;
   logic [1:0]    r_hv;
   logic [PW-1:0] r_ptr;
   logic          r_len_err;
   logic          r_ld_err;

   logic          w_cur;
   logic [PW-2:0] w_off;
   logic [PW-1:0] w_avail;
   logic          w_vde;
   logic          w_restart;
   logic          w_norm_ld;
   logic          w_ld_idx;
   logic          w_len_ok;
   logic [PW-1:0] w_ptr_sum;
   logic [1:0]    w_hv_nxt;
   logic [PW-1:0] w_ptr_nxt;
   logic          w_wr0;
   logic          w_wr1;
   logic          w_len_err;
   logic          w_ld_err;
   logic [7:0]    w_bytes [BUF_BYTES];

   assign w_cur     = r_ptr[PW-1];
   assign w_off     = r_ptr[PW-2:0];
   assign w_restart = (f_ld_buf == 2'b11);
   assign w_norm_ld = (f_ld_buf == 2'b01) || (f_ld_buf == 2'b10);
   assign w_ld_idx  = f_ld_buf[1];
   assign w_len_ok  = (de_len != '0) && (de_len <= PW'(LINE_BYTES));
   assign w_ptr_sum = r_ptr + de_len;

   // Contiguous valid bytes from ptr: the current half from off onward,
   // extended to a full window when the other half is also valid.
   always_comb begin
      w_avail = '0;
      if (r_hv[w_cur]) begin
         if (r_hv[~w_cur]) w_avail = PW'(LINE_BYTES);
         else              w_avail = PW'(LINE_BYTES) - PW'(w_off);
      end
   end

   assign w_vde = (w_avail == PW'(LINE_BYTES));

   // Byte view of the whole buffer, half 0 first.
   for (genvar j = 0; j < int'(LINE_BYTES); j++) begin : g_bytes
      assign w_bytes[j]              = r_buf0[8*j +: 8];
      assign w_bytes[j + LINE_BYTES] = r_buf1[8*j +: 8];
   end

   // Rotated window; the PW-bit index wraps naturally modulo the buffer size.
   always_comb begin
      win_bytes = '0;
      for (int unsigned k = 0; k < LINE_BYTES; k++) begin
         win_bytes[8*k +: 8] = w_bytes[r_ptr + PW'(k)];
      end
   end

   // Next state: flush beats everything, restart beats take; a take's free is
   // applied before a normal load looks at the half-valid bits.
   always_comb begin
      w_hv_nxt  = r_hv;
      w_ptr_nxt = r_ptr;
      w_wr0     = 1'b0;
      w_wr1     = 1'b0;
      w_len_err = 1'b0;
      w_ld_err  = 1'b0;
      if (flush) begin
         w_hv_nxt  = '0;
         w_ptr_nxt = flush_off;
      end else if (w_restart) begin
         w_hv_nxt[w_cur]  = 1'b1;
         w_hv_nxt[~w_cur] = 1'b0;
         w_wr0            = ~w_cur;
         w_wr1            = w_cur;
      end else begin
         if (de_take && w_vde) begin
            if (w_len_ok) begin
               w_ptr_nxt = w_ptr_sum;
               // Leaving the current half (incl. landing on a boundary) frees it.
               if (w_ptr_sum[PW-1] != w_cur) w_hv_nxt[w_cur] = 1'b0;
            end else begin
               w_len_err = 1'b1;
            end
         end
         if (w_norm_ld) begin
            if (!w_hv_nxt[w_ld_idx]) begin
               w_hv_nxt[w_ld_idx] = 1'b1;
               w_wr0              = ~w_ld_idx;
               w_wr1              = w_ld_idx;
            end else begin
               w_ld_err = 1'b1;
            end
         end
      end
   end

   // Control state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hv      <= '0;
         r_ptr     <= '0;
         r_len_err <= 1'b0;
         r_ld_err  <= 1'b0;
      end else begin
         r_hv      <= w_hv_nxt;
         r_ptr     <= w_ptr_nxt;
         r_len_err <= w_len_err;
         r_ld_err  <= w_ld_err;
      end
   end

   // Buffer data; contents are don't-care until the half is marked valid.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr0) r_buf0 <= f_line;
      if (rst_n && w_wr1) r_buf1 <= f_line;
   end

   assign r_V_de    = w_vde;
   assign win_avail = w_avail;
   assign de_p      = w_cur;
   assign len_err   = r_len_err;
   assign ld_err    = r_ld_err;

endmodule

// File: tb/tb_fetch_buf_reader.sv
// tb_fetch_buf_reader: directed scenarios plus randomized traffic checked
// against a byte-array model of the fetch buffer (LINE_BYTES = 16).
module tb_fetch_buf_reader;

   logic         clk;
   logic         rst_n;
   logic [1:0]   f_ld_buf;
   logic [127:0] f_line;
   logic         flush;
   logic [4:0]   flush_off;
   logic         de_take;
   logic [4:0]   de_len;
   logic [127:0] win_bytes;
   logic         r_V_de;
   logic [4:0]   win_avail;
   logic         de_p;
   logic         len_err;
   logic         ld_err;

   int checks = 0;
   int errors = 0;

   // Reference model: 32 bytes, two half-valid flags, byte pointer.
   logic [7:0] m_mem [32];
   bit   [1:0] m_hv;
   int         m_ptr;
   bit         m_lerr;
   bit         m_derr;

   fetch_buf_reader #(.LINE_BYTES(16)) dut (
      .clk(clk), .rst_n(rst_n), .f_ld_buf(f_ld_buf), .f_line(f_line),
      .flush(flush), .flush_off(flush_off), .de_take(de_take), .de_len(de_len),
      .win_bytes(win_bytes), .r_V_de(r_V_de), .win_avail(win_avail),
      .de_p(de_p), .len_err(len_err), .ld_err(ld_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] make_line(input int base);
      logic [127:0] l;
      for (int k = 0; k < 16; k++) l[8*k +: 8] = 8'((base + k) & 255);
      return l;
   endfunction

   // Count valid bytes walking forward from the pointer, up to 16.
   function automatic int model_avail();
      int  n;
      bit  stop;
      n = 0;
      stop = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (!stop) begin
            if (m_hv[((m_ptr + k) % 32) / 16]) n++;
            else stop = 1'b1;
         end
      end
      return n;
   endfunction

   function automatic void model_write(input int half, input logic [127:0] line);
      for (int k = 0; k < 16; k++) m_mem[half*16 + k] = line[8*k +: 8];
   endfunction

   // Apply one cycle of inputs to DUT and model; returns #1 after the edge.
   task automatic step(input bit rst, input bit fl, input int foff, input bit tk,
                       input int len, input int ld, input logic [127:0] line);
      int cur;
      int av;
      int np;
      int idx;
      rst_n = rst; flush = fl; flush_off = 5'(foff); de_take = tk;
      de_len = 5'(len); f_ld_buf = 2'(ld); f_line = line;
      @(posedge clk);
      m_lerr = 1'b0;
      m_derr = 1'b0;
      if (!rst) begin
         m_hv = 2'b00; m_ptr = 0;
      end else if (fl) begin
         m_hv = 2'b00; m_ptr = foff;
      end else begin
         cur = m_ptr / 16;
         av  = model_avail();
         if (ld == 3) begin
            model_write(cur, line);
            m_hv[cur] = 1'b1;
            m_hv[1-cur] = 1'b0;
         end else begin
            if (tk && av == 16) begin
               if (len >= 1 && len <= 16) begin
                  np = (m_ptr + len) % 32;
                  if (np / 16 != cur) m_hv[cur] = 1'b0;
                  m_ptr = np;
               end else begin
                  m_lerr = 1'b1;
               end
            end
            if (ld == 1 || ld == 2) begin
               idx = (ld == 2) ? 1 : 0;
               if (!m_hv[idx]) begin
                  model_write(idx, line);
                  m_hv[idx] = 1'b1;
               end else begin
                  m_derr = 1'b1;
               end
            end
         end
      end
      #1;
      rst_n = 1'b1; flush = 1'b0; de_take = 1'b0; f_ld_buf = 2'b00;
   endtask

   task automatic test_reset();
      step(0, 0, 0, 0, 0, 0, '0);
      checks++; if (r_V_de !== 1'b0) begin errors++; $display("FAIL reset_vde: got %0b want 0", r_V_de); end
      checks++; if (win_avail !== 5'd0) begin errors++; $display("FAIL reset_avail: got %0d want 0", win_avail); end
      checks++; if (de_p !== 1'b0) begin errors++; $display("FAIL reset_dep: got %0b want 0", de_p); end
      checks++; if ({len_err, ld_err} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {len_err, ld_err}); end
   endtask

   task automatic test_restart_load();
      step(1, 0, 0, 0, 0, 3, make_line(8'h00));
      checks++; if (r_V_de !== 1'b1) begin errors++; $display("FAIL restart_vde: got %0b want 1", r_V_de); end
      checks++; if (win_avail !== 5'd16) begin errors++; $display("FAIL restart_avail: got %0d want 16", win_avail); end
      checks++; if (win_bytes[7:0] !== 8'h00 || de_p !== 1'b0) begin errors++; $display("FAIL restart_win: got byte0=%h de_p=%0b want 00/0", win_bytes[7:0], de_p); end
   endtask

   task automatic test_consume();
      step(1, 0, 0, 0, 0, 2, make_line(8'h10));
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 5, 0, '0);
      checks++; if (win_bytes[7:0] !== 8'h0F || win_avail !== 5'd16) begin errors++; $display("FAIL consume15: got byte0=%h avail=%0d want 0f/16", win_bytes[7:0], win_avail); end
      step(1, 0, 0, 1, 3, 0, '0);
      checks++; if (de_p !== 1'b1 || win_avail !== 5'd14 || r_V_de !== 1'b0) begin errors++; $display("FAIL consume18: got de_p=%0b avail=%0d vde=%0b want 1/14/0", de_p, win_avail, r_V_de); end
      step(1, 0, 0, 0, 0, 1, make_line(8'h20));
      checks++; if (win_bytes[14*8 +: 8] !== 8'h20 || win_avail !== 5'd16) begin errors++; $display("FAIL refill0: got byte14=%h avail=%0d want 20/16", win_bytes[14*8 +: 8], win_avail); end
   endtask

   task automatic test_wrap_free();
      step(1, 0, 0, 1, 10, 0, '0);
      checks++; if (win_bytes[7:0] !== 8'h1C || de_p !== 1'b1) begin errors++; $display("FAIL ptr28: got byte0=%h de_p=%0b want 1c/1", win_bytes[7:0], de_p); end
      step(1, 0, 0, 1, 4, 2, make_line(8'h30));
      checks++; if (de_p !== 1'b0 || win_avail !== 5'd16 || win_bytes[7:0] !== 8'h20) begin errors++; $display("FAIL wrap: got de_p=%0b avail=%0d byte0=%h want 0/16/20", de_p, win_avail, win_bytes[7:0]); end
      checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL wrap_lderr: got %0b want 0", ld_err); end
      step(1, 0, 0, 1, 16, 0, '0);
      checks++; if (win_bytes[7:0] !== 8'h30 || de_p !== 1'b1 || win_avail !== 5'd16) begin errors++; $display("FAIL wrap_newdata: got byte0=%h de_p=%0b avail=%0d want 30/1/16", win_bytes[7:0], de_p, win_avail); end
   endtask

   task automatic test_flush();
      step(1, 1, 7, 1, 4, 1, make_line(8'h99));
      checks++; if (r_V_de !== 1'b0 || win_avail !== 5'd0 || de_p !== 1'b0) begin errors++; $display("FAIL flush: got vde=%0b avail=%0d de_p=%0b want 0/0/0", r_V_de, win_avail, de_p); end
      checks++; if ({len_err, ld_err} !== 2'b00) begin errors++; $display("FAIL flush_err: got %b want 00", {len_err, ld_err}); end
      step(1, 0, 0, 0, 0, 3, make_line(8'h40));
      checks++; if (win_avail !== 5'd9 || r_V_de !== 1'b0 || win_bytes[7:0] !== 8'h47) begin errors++; $display("FAIL flush_restart: got avail=%0d vde=%0b byte0=%h want 9/0/47", win_avail, r_V_de, win_bytes[7:0]); end
   endtask

   task automatic test_illegal();
      step(1, 0, 0, 0, 0, 2, make_line(8'h50));
      step(1, 0, 0, 1, 0, 0, '0);
      checks++; if (len_err !== 1'b1 || win_bytes[7:0] !== 8'h47) begin errors++; $display("FAIL len0: got len_err=%0b byte0=%h want 1/47", len_err, win_bytes[7:0]); end
      step(1, 0, 0, 0, 0, 0, '0);
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_pulse: got %0b want 0", len_err); end
      step(1, 0, 0, 1, 17, 0, '0);
      checks++; if (len_err !== 1'b1 || win_bytes[7:0] !== 8'h47) begin errors++; $display("FAIL len17: got len_err=%0b byte0=%h want 1/47", len_err, win_bytes[7:0]); end
      step(1, 0, 0, 0, 0, 1, make_line(8'hA0));
      checks++; if (ld_err !== 1'b1 || win_bytes[7:0] !== 8'h47) begin errors++; $display("FAIL ld_occ: got ld_err=%0b byte0=%h want 1/47", ld_err, win_bytes[7:0]); end
      step(1, 0, 0, 0, 0, 0, '0);
      checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL ld_pulse: got %0b want 0", ld_err); end
   endtask

   task automatic test_reset_mid();
      step(1, 0, 0, 1, 13, 0, '0);
      checks++; if (de_p !== 1'b1 || win_bytes[7:0] !== 8'h54) begin errors++; $display("FAIL ptr20: got de_p=%0b byte0=%h want 1/54", de_p, win_bytes[7:0]); end
      step(0, 0, 0, 1, 4, 1, make_line(8'h60));
      checks++; if ({r_V_de, win_avail, de_p, len_err, ld_err} !== 9'd0) begin errors++; $display("FAIL reset_mid: got vde=%0b avail=%0d de_p=%0b errs=%b want all 0", r_V_de, win_avail, de_p, {len_err, ld_err}); end
   endtask

   task automatic test_random();
      int ld, len, av;
      bit rst, fl, tk, bad;
      logic [127:0] line;
      step(0, 0, 0, 0, 0, 0, '0);
      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 199) != 0);
         fl   = ($urandom_range(0, 39) == 0);
         tk   = ($urandom_range(0, 2) != 0);
         len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 16));
         ld   = ($urandom_range(0, 14) == 0) ? 3 : int'($urandom_range(0, 2));
         line = {$urandom, $urandom, $urandom, $urandom};
         step(rst, fl, int'($urandom_range(0, 31)), tk, len, ld, line);
         av = model_avail();
         checks++; if (win_avail !== 5'(av)) begin errors++; $display("FAIL rnd_avail[%0d]: got %0d want %0d", n, win_avail, av); end
         checks++; if (r_V_de !== (av == 16)) begin errors++; $display("FAIL rnd_vde[%0d]: got %0b want %0b", n, r_V_de, av == 16); end
         checks++; if (de_p !== 1'(m_ptr / 16)) begin errors++; $display("FAIL rnd_dep[%0d]: got %0b want %0d", n, de_p, m_ptr / 16); end
         checks++; if (len_err !== m_lerr || ld_err !== m_derr) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, {len_err, ld_err}, {m_lerr, m_derr}); end
         bad = 1'b0;
         for (int k = 0; k < av; k++) if (win_bytes[8*k +: 8] !== m_mem[(m_ptr + k) % 32]) bad = 1'b1;
         checks++; if (bad) begin errors++; $display("FAIL rnd_win[%0d]: got %h ptr=%0d avail=%0d", n, win_bytes, m_ptr, av); end
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; flush_off = '0; de_take = 1'b0;
      de_len = '0; f_ld_buf = 2'b00; f_line = '0;
      m_hv = 2'b00; m_ptr = 0; m_lerr = 1'b0; m_derr = 1'b0;
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
      @(negedge clk);
      test_reset();
      test_restart_load();
      test_consume();
      test_wrap_free();
      test_flush();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
